// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE,
    RESP,
    ERR
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_07fe;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling: load extract/extend and store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{offset, 3'b000} +: 8] = data[7:0];
      2'b01:   store_word[{offset[1], 4'b0000} +: 16] = data[15:0];
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a single word-wide memory port,
// using read-modify-write for sub-word stores and a raw bypass for the display MMIO word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] MMIO_ADDR    = MMIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  lsu_state_e  state;
  logic [CW-1:0] cnt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;

  logic        illegal;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state == IDLE);

  always_comb begin
    if (req_store)
      illegal = req_funct3[2] || (req_funct3 == 3'b011);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // mem_addr still holds the request address, so its low bits select the lane
  lsu_lane_align u_align (
    .word       (mem_rdata),
    .offset     (mem_addr[1:0]),
    .funct3     (funct3_q),
    .data       (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            funct3_q   <= req_funct3;
            wdata_q    <= req_wdata[15:0];
            mem_addr   <= req_addr;
            resp_rdata <= '0;
            // Illegal funct3 wins over the MMIO bypass; alignment does not
            if (illegal) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_store && (req_addr == MMIO_ADDR)) begin
              state     <= WRITE;
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
            end else if (misaligned) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_store && (req_funct3 == F3_W)) begin
              state     <= WRITE;
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
            end else begin
              state <= READ_WAIT;
              cnt   <= CW'(READ_LATENCY);
            end
          end
        end
        READ_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (store_q) begin
            state     <= WRITE;
            mem_wdata <= store_word;
            mem_we    <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        ERR: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
